// File: rtl/shift_sequencer.sv
// shift_sequencer: word-level exchange engine for an N-bit serial shift chain.
// Define SHIFT_SEQ_MSB_FIRST_EN to send and capture MSB first (default build is LSB first).
module shift_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         sr_si,
  output logic         sr_en,
  input  logic         sr_so,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t        state_reg;
  logic [N-1:0]  tx_reg;
  logic [N-1:0]  rx_reg;
  logic [CW-1:0] cnt_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          sr_en_reg;
  logic          busy_reg;

  logic [CW-1:0] rx_idx;
  logic [N-1:0]  tx_next;
  logic [N-1:0]  rx_next;
  logic          tx_bit;

  // TX drains with zero fill, so once a word is fully sent sr_si rests at 0.
`ifdef SHIFT_SEQ_MSB_FIRST_EN
  assign rx_idx  = CNT_LAST - cnt_reg;
  assign tx_next = {tx_reg[N-2:0], 1'b0};
  assign tx_bit  = tx_reg[N-1];
`else
  assign rx_idx  = cnt_reg;
  assign tx_next = {1'b0, tx_reg[N-1:1]};
  assign tx_bit  = tx_reg[0];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rx
      assign rx_next[gi] = (rx_idx == CW'(gi)) ? sr_so : rx_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      tx_reg        <= '0;
      rx_reg        <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      sr_en_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg    <= SHIFT;
            tx_reg       <= in_data;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            sr_en_reg    <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        SHIFT: begin
          rx_reg  <= rx_next;
          tx_reg  <= tx_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == CNT_LAST) begin
            state_reg     <= HOLD;
            sr_en_reg     <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          sr_en_reg     <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg & ~rst;
  assign out_valid = out_valid_reg;
  assign out_data  = rx_reg;
  assign sr_en     = sr_en_reg;
  assign sr_si     = tx_bit;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: models the physical chain plus a word-exchange reference.
// Honours SHIFT_SEQ_MSB_FIRST_EN for the bit-order expectations.
module tb_shift_sequencer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         sr_si;
  logic         sr_en;
  logic         sr_so;
  logic         busy;

  shift_sequencer #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sr_si    (sr_si),
    .sr_en    (sr_en),
    .sr_so    (sr_so),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Physical chain: first stage takes sr_si, last stage drives sr_so.
  logic [N-1:0] chain;
  logic [N-1:0] chain_next;
  assign chain_next = sr_en ? {chain[N-2:0], sr_si} : chain;
  assign sr_so      = chain[N-1];

  // Reference model state
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           n_acc = 0;
  int           shifts_left = 0;
  bit           m_busy = 1'b0;
  bit           m_hold = 1'b0;
  bit           m_reset_seen = 1'b0;
  bit           rand_ready = 1'b0;
  bit           prev_ov = 1'b0;
  logic [N-1:0] m_tx = '0;
  logic [N-1:0] model_word = '0;
  logic [N-1:0] exp_out = '0;
  logic [N-1:0] si_seq = '0;
  int           acc_log[$];
  int           rise_log[$];
  logic [N-1:0] out_log[$];

  // Word the next transaction returns, given the chain's current contents.
  function automatic logic [N-1:0] decode(input logic [N-1:0] c);
    logic [N-1:0] r;
`ifdef SHIFT_SEQ_MSB_FIRST_EN
    r = c;
`else
    for (int i = 0; i < N; i++) r[i] = c[N-1-i];
`endif
    return r;
  endfunction

  function automatic logic exp_si(input logic [N-1:0] w, input int k);
`ifdef SHIFT_SEQ_MSB_FIRST_EN
    return w[N-1-k];
`else
    return w[k];
`endif
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, got no event expected one (cycle %0d)", name, cyc);
  endtask

  // Model advances on each edge using pre-edge inputs and DUT outputs.
  always @(posedge clk) begin
    chain <= chain_next;
    cyc   <= cyc + 1;
    if (shifts_left != 0) si_seq[N - shifts_left] <= sr_si;
    if (rst) begin
      m_busy       <= 1'b0;
      m_hold       <= 1'b0;
      shifts_left  <= 0;
      m_reset_seen <= 1'b1;
      if (shifts_left != 0) model_word <= decode(chain_next);
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy      <= 1'b1;
        shifts_left <= N;
        m_tx        <= in_data;
        exp_out     <= model_word;
        model_word  <= in_data;
        n_acc       <= n_acc + 1;
        acc_log.push_back(cyc);
      end
    end else if (shifts_left != 0) begin
      shifts_left <= shifts_left - 1;
      if (shifts_left == 1) m_hold <= 1'b1;
    end else if (m_hold && out_ready) begin
      m_hold <= 1'b0;
      m_busy <= 1'b0;
      out_log.push_back(out_data);
      $display("txn %0d: sent %h returned %h expected %h", n_acc, m_tx, out_data, exp_out);
    end
  end

  // Compare every cycle once the DUT has seen a reset.
  always @(negedge clk) begin
    if (m_reset_seen) begin
      chk1("in_ready", in_ready, !m_busy && !rst);
      chk1("sr_en", sr_en, shifts_left != 0);
      chk1("sr_si", sr_si, (shifts_left != 0) ? exp_si(m_tx, N - shifts_left) : 1'b0);
      chk1("out_valid", out_valid, m_hold);
      chk1("busy", busy, m_busy);
      if (m_hold) chkw("out_data", out_data, exp_out);
    end
    if (out_valid === 1'b1 && !prev_ov) rise_log.push_back(cyc);
    prev_ov <= (out_valid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit keep);
    int start;
    bit done;
    start    = n_acc;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (n_acc != start) done = 1'b1;
    end
    if (!done) timeout("accept");
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      if (!m_busy) done = 1'b1;
      else tick();
    end
    if (!done) timeout("idle");
  endtask

  logic [N-1:0] bp_word;
  logic [N-1:0] exp_seq;
  int           a0;
  int           n0;
  int           o0;
  int           ov_cnt;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h77;
    out_ready  = 1'b1;
    chain      = N'($urandom);
    model_word = decode(chain);

    // Reset held two cycles with in_valid high: nothing may be accepted.
    tick();
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("rstval_in_ready", in_ready, 1'b1);
    chk1("rstval_out_valid", out_valid, 1'b0);
    chkw("rstval_out_data", out_data, 8'h00);
    chk1("rstval_sr_en", sr_en, 1'b0);
    chk1("rstval_sr_si", sr_si, 1'b0);
    chk1("rstval_busy", busy, 1'b0);

    // Bit order, exchange and output latency.
    send_word(8'hA5, 1'b0);
    wait_idle();
    send_word(8'h01, 1'b0);
    a0 = acc_log[$];
    wait_idle();
`ifdef SHIFT_SEQ_MSB_FIRST_EN
    exp_seq = 8'h80;
`else
    exp_seq = 8'h01;
`endif
    chkw("si_order", si_seq, exp_seq);
    chkw("exchange", out_log[$], 8'hA5);
    chki("latency", rise_log[$] - a0, N + 1);

    // Backpressure: five cycles of out_ready low in HOLD.
    out_ready = 1'b0;
    bp_word   = N'($urandom);
    send_word(bp_word, 1'b0);
    for (int i = 0; i < 50 && !m_hold; i++) tick();
    if (!m_hold) timeout("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chkw("bp_out_data", out_data, 8'h01);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_sr_en", sr_en, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk1("bp_release_in_ready", in_ready, 1'b1);
    chk1("bp_release_busy", busy, 1'b0);

    // Back-to-back with in_valid held high.
    send_word(8'h3C, 1'b1);
    n0 = acc_log.size() - 1;
    o0 = out_log.size();
    send_word(8'h00, 1'b1);
    send_word(8'hFF, 1'b1);
    send_word(8'h81, 1'b0);
    wait_idle();
    chki("b2b_accepts", acc_log.size() - n0, 4);
    chki("b2b_outputs", out_log.size() - o0, 4);
    if (out_log.size() == o0 + 4) begin
      chkw("b2b_out0", out_log[o0], bp_word);
      chkw("b2b_out1", out_log[o0+1], 8'h3C);
      chkw("b2b_out2", out_log[o0+2], 8'h00);
      chkw("b2b_out3", out_log[o0+3], 8'hFF);
    end
    if (acc_log.size() == n0 + 4)
      for (int i = 0; i < 3; i++) chki("b2b_spacing", acc_log[n0+i+1] - acc_log[n0+i], N + 2);

    // Reset after three shift cycles aborts the transaction.
    send_word(N'($urandom), 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_sr_en", sr_en, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b1);
    ov_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_cnt++;
      tick();
    end
    chki("abort_no_out_valid", ov_cnt, 0);

    // Round trip of a known word.
    send_word(8'hC3, 1'b0);
    wait_idle();
    send_word(N'($urandom), 1'b0);
    wait_idle();
    chkw("roundtrip", out_log[$], 8'hC3);

    // Randomised traffic with random gaps and random out_ready.
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_word(N'($urandom), ($urandom_range(0, 3) == 0));
    end
    in_valid = 1'b0;
    wait_idle();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
